// File: rtl/vm1_vic.sv
// vm1_vic - vectored interrupt controller for the processor's vector port.
//
// Collects level requests from peripherals, raises virq_o, and answers the
// processor's vector fetch (wbi_stb_i / wbi_ack_o / wbi_dat_o) with the vector
// of the highest-priority pending source (index 0 highest). The granted source
// receives a one-cycle iack_o pulse so it can drop its request.
//
// Ports:
//   wb_clk_i   in   1     system clock, rising edge
//   wb_rst_i   in   1     asynchronous active-high reset
//   ireq_i     in   N     level interrupt requests
//   ivec_i     in   16*N  packed vectors, source k at [16k+15:16k]
//   iack_o     out  N     one-hot grant pulse to the serviced source
//   virq_o     out  1     vectored interrupt request
//   wbi_stb_i  in   1     vector fetch strobe
//   wbi_ack_o  out  1     vector fetch acknowledge pulse
//   wbi_dat_o  out  16    delivered vector, held until the next delivery
//
// State    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | virq_o tracks requests; a strobe is answered next cycle
// ACK      | wbi_ack_o / iack_o high for exactly this cycle
// WAIT     | strobe still high after the ack; no second ack for it
// HOLD     | virq_o suppressed for HOLD cycles so stale requests settle

module vm1_vic #(
    parameter int          N     = 8,
    parameter int          HOLD  = 2,
    parameter logic [15:0] NOVEC = 16'o000000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [N-1:0]    ireq_i,
    input  logic [16*N-1:0] ivec_i,
    output logic [N-1:0]    iack_o,
    output logic            virq_o,
    input  logic            wbi_stb_i,
    output logic            wbi_ack_o,
    output logic [15:0]     wbi_dat_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_W = 4'(HOLD);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           virq_q, virq_d;
    logic           ack_q, ack_d;
    logic [N-1:0]   iack_q, iack_d;
    logic [15:0]    dat_q, dat_d;

    logic           pend;
    logic [N-1:0]   grant;
    logic [15:0]    sel_vec;

    // Priority encoder: first set bit from index 0 upward wins.
    always_comb begin
        pend    = 1'b0;
        grant   = '0;
        sel_vec = 16'h0000;
        for (int k = 0; k < N; k++) begin
            if (ireq_i[k] && !pend) begin
                pend     = 1'b1;
                grant[k] = 1'b1;
                sel_vec  = ivec_i[16*k +: 16];
            end
        end
    end

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            virq_q  <= 1'b0;
            ack_q   <= 1'b0;
            iack_q  <= '0;
            dat_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            virq_q  <= virq_d;
            ack_q   <= ack_d;
            iack_q  <= iack_d;
            dat_q   <= dat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (wbi_stb_i) state_d = S_ACK;
            end
            S_ACK, S_WAIT: begin
                if (state_q == S_ACK && wbi_stb_i) begin
                    state_d = S_WAIT;
                end else if (!wbi_stb_i) begin
                    if (HOLD_W == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_W;
                    end
                end
            end
            S_HOLD: begin
                // Leave when this decrement reaches zero, giving exactly
                // HOLD cycles spent in this state.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic (registered through the _d/_q pairs)
    always_comb begin
        virq_d = 1'b0;
        ack_d  = 1'b0;
        iack_d = '0;
        dat_d  = dat_q;
        if (state_q == S_IDLE) begin
            if (wbi_stb_i) begin
                ack_d  = 1'b1;
                iack_d = grant;
                // Vectors are word-aligned: the two low bits are never delivered.
                dat_d  = (pend ? sel_vec : NOVEC) & 16'hFFFC;
            end else begin
                virq_d = pend;
            end
        end
    end

    assign iack_o    = iack_q;
    assign virq_o    = virq_q;
    assign wbi_ack_o = ack_q;
    assign wbi_dat_o = dat_q;

endmodule

// File: tb/tb_vm1_vic.sv
module tb_vm1_vic;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i;
    logic [7:0]   ireq_i;
    logic [127:0] ivec_i;
    logic [7:0]   iack_o;
    logic         virq_o;
    logic         wbi_stb_i;
    logic         wbi_ack_o;
    logic [15:0]  wbi_dat_o;

    int n_cmp = 0;
    int n_err = 0;

    vm1_vic #(.N(8), .HOLD(2), .NOVEC(16'o000000)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .ireq_i    (ireq_i),
        .ivec_i    (ivec_i),
        .iack_o    (iack_o),
        .virq_o    (virq_o),
        .wbi_stb_i (wbi_stb_i),
        .wbi_ack_o (wbi_ack_o),
        .wbi_dat_o (wbi_dat_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        wb_rst_i  = 1'b1;
        ireq_i    = 8'h04;
        wbi_stb_i = 1'b1;
        ivec_i    = '0;
        ivec_i[2*16 +: 16] = 16'o000064;
        idle(2);
        n_cmp++; if (virq_o !== 1'b0) begin n_err++; $display("FAIL rst_virq got %b exp 0", virq_o); end
        n_cmp++; if (wbi_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack got %b exp 0", wbi_ack_o); end
        n_cmp++; if (iack_o !== 8'h00) begin n_err++; $display("FAIL rst_iack got %h exp 00", iack_o); end
        n_cmp++; if (wbi_dat_o !== 16'h0000) begin n_err++; $display("FAIL rst_dat got %o exp 0", wbi_dat_o); end
        wb_rst_i  = 1'b0;
        wbi_stb_i = 1'b0;
        tick();
        n_cmp++; if (virq_o !== 1'b1) begin n_err++; $display("FAIL rst_rel_virq got %b exp 1", virq_o); end
        n_cmp++; if (wbi_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_rel_ack got %b exp 0", wbi_ack_o); end
        wbi_stb_i = 1'b1;
        tick();
        n_cmp++; if (wbi_ack_o !== 1'b1) begin n_err++; $display("FAIL rst_fetch_ack got %b exp 1", wbi_ack_o); end
        n_cmp++; if (iack_o !== 8'h04) begin n_err++; $display("FAIL rst_fetch_iack got %h exp 04", iack_o); end
        n_cmp++; if (wbi_dat_o !== 16'o000064) begin n_err++; $display("FAIL rst_fetch_dat got %o exp 64", wbi_dat_o); end
        wbi_stb_i = 1'b0;
        ireq_i    = 8'h00;
        idle(6);
    endtask

    task automatic test_single();
        ireq_i = 8'h04;
        ivec_i[2*16 +: 16] = 16'o000064;
        tick();
        n_cmp++; if (virq_o !== 1'b1) begin n_err++; $display("FAIL single_virq got %b exp 1", virq_o); end
        wbi_stb_i = 1'b1;
        tick();
        n_cmp++; if (wbi_ack_o !== 1'b1) begin n_err++; $display("FAIL single_ack got %b exp 1", wbi_ack_o); end
        n_cmp++; if (wbi_dat_o !== 16'o000064) begin n_err++; $display("FAIL single_dat got %o exp 64", wbi_dat_o); end
        n_cmp++; if (iack_o !== 8'h04) begin n_err++; $display("FAIL single_iack got %h exp 04", iack_o); end
        n_cmp++; if (virq_o !== 1'b0) begin n_err++; $display("FAIL single_virq_ack got %b exp 0", virq_o); end
        ireq_i = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (wbi_ack_o !== 1'b0) begin n_err++; $display("FAIL single_no_reack[%0d] got %b exp 0", i, wbi_ack_o); end
            n_cmp++; if (iack_o !== 8'h00) begin n_err++; $display("FAIL single_no_reiack[%0d] got %h exp 00", i, iack_o); end
        end
        wbi_stb_i = 1'b0;
        idle(6);
    endtask

    task automatic test_priority();
        ireq_i = 8'h0A;
        ivec_i[1*16 +: 16] = 16'o000100;
        ivec_i[3*16 +: 16] = 16'o000300;
        tick();
        wbi_stb_i = 1'b1;
        tick();
        n_cmp++; if (wbi_dat_o !== 16'o000100) begin n_err++; $display("FAIL prio1_dat got %o exp 100", wbi_dat_o); end
        n_cmp++; if (iack_o !== 8'h02) begin n_err++; $display("FAIL prio1_iack got %h exp 02", iack_o); end
        wbi_stb_i = 1'b0;
        ireq_i    = 8'h08;
        idle(6);
        wbi_stb_i = 1'b1;
        tick();
        n_cmp++; if (wbi_dat_o !== 16'o000300) begin n_err++; $display("FAIL prio2_dat got %o exp 300", wbi_dat_o); end
        n_cmp++; if (iack_o !== 8'h08) begin n_err++; $display("FAIL prio2_iack got %h exp 08", iack_o); end
        wbi_stb_i = 1'b0;
    endtask

    // Continues from test_priority: ACK cycle in progress, ireq_i still 8'h08.
    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (virq_o !== 1'b0) begin n_err++; $display("FAIL hold_virq[%0d] got %b exp 0", i, virq_o); end
        end
        tick();
        n_cmp++; if (virq_o !== 1'b1) begin n_err++; $display("FAIL hold_virq_back got %b exp 1", virq_o); end
        n_cmp++; if (wbi_dat_o !== 16'o000300) begin n_err++; $display("FAIL hold_dat_held got %o exp 300", wbi_dat_o); end
        ireq_i = 8'h00;
        idle(3);
    endtask

    task automatic test_novec();
        ireq_i = 8'h01;
        ivec_i[0 +: 16] = 16'o000200;
        tick();
        n_cmp++; if (virq_o !== 1'b1) begin n_err++; $display("FAIL novec_virq got %b exp 1", virq_o); end
        ireq_i    = 8'h00;
        wbi_stb_i = 1'b1;
        tick();
        n_cmp++; if (wbi_ack_o !== 1'b1) begin n_err++; $display("FAIL novec_ack got %b exp 1", wbi_ack_o); end
        n_cmp++; if (wbi_dat_o !== 16'o000000) begin n_err++; $display("FAIL novec_dat got %o exp 0", wbi_dat_o); end
        n_cmp++; if (iack_o !== 8'h00) begin n_err++; $display("FAIL novec_iack got %h exp 00", iack_o); end
        wbi_stb_i = 1'b0;
        idle(6);
    endtask

    task automatic test_vec_mask();
        ireq_i = 8'h01;
        ivec_i[0 +: 16] = 16'o000107;
        tick();
        wbi_stb_i = 1'b1;
        tick();
        n_cmp++; if (wbi_dat_o !== 16'o000104) begin n_err++; $display("FAIL mask_dat got %o exp 104", wbi_dat_o); end
        n_cmp++; if (iack_o !== 8'h01) begin n_err++; $display("FAIL mask_iack got %h exp 01", iack_o); end
        wbi_stb_i = 1'b0;
        ireq_i    = 8'h00;
        idle(6);
    endtask

    task automatic test_reset_mid();
        ireq_i = 8'h04;
        ivec_i[2*16 +: 16] = 16'o000064;
        tick();
        wbi_stb_i = 1'b1;
        #3;
        wb_rst_i = 1'b1;
        #1;
        n_cmp++; if (wbi_ack_o !== 1'b0) begin n_err++; $display("FAIL mid_ack_async got %b exp 0", wbi_ack_o); end
        n_cmp++; if (virq_o !== 1'b0) begin n_err++; $display("FAIL mid_virq_async got %b exp 0", virq_o); end
        tick();
        n_cmp++; if (wbi_ack_o !== 1'b0) begin n_err++; $display("FAIL mid_ack got %b exp 0", wbi_ack_o); end
        n_cmp++; if (iack_o !== 8'h00) begin n_err++; $display("FAIL mid_iack got %h exp 00", iack_o); end
        wb_rst_i  = 1'b0;
        wbi_stb_i = 1'b0;
        tick();
        n_cmp++; if (wbi_ack_o !== 1'b0) begin n_err++; $display("FAIL mid_rel_ack got %b exp 0", wbi_ack_o); end
        n_cmp++; if (virq_o !== 1'b1) begin n_err++; $display("FAIL mid_rel_virq got %b exp 1", virq_o); end
        wbi_stb_i = 1'b1;
        tick();
        n_cmp++; if (wbi_ack_o !== 1'b1) begin n_err++; $display("FAIL mid_new_ack got %b exp 1", wbi_ack_o); end
        n_cmp++; if (iack_o !== 8'h04) begin n_err++; $display("FAIL mid_new_iack got %h exp 04", iack_o); end
        wbi_stb_i = 1'b0;
        ireq_i    = 8'h00;
        idle(4);
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_hold();
        test_novec();
        test_vec_mask();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vm1_vic.md
Name: vm1_vic

Overview:
Vectored interrupt controller feeding the processor module's interrupt vector port (virq request, wbi_stb/wbi_ack/wbi_dat handshake).
- Collects level-sensitive requests from on-chip peripherals and raises one vectored request line.
- Answers the processor's interrupt-acknowledge vector fetch with the vector of the highest-priority pending source.
- Pulses a per-source acknowledge so the granted device drops its request.

Parameters:
N, 8, number of interrupt sources (1..16); index 0 has the highest priority.
HOLD, 2, cycles virq_o stays suppressed after a vector delivery, so a stale request is not re-sampled (0..15).
NOVEC, 16'o000000, vector returned when a fetch finds no pending request.

Ports:
wb_clk_i  in  1  system clock; all logic is on the rising edge.
wb_rst_i  in  1  reset, asynchronous, active-high.
ireq_i  in  N  peripheral interrupt requests, level, active-high.
ivec_i  in  16*N  packed vectors; source k uses bits [16k+15:16k]; static while a request is pending.
iack_o  out  N  one-cycle grant pulse to the serviced source.
virq_o  out  1  vectored interrupt request to the processor module.
wbi_stb_i  in  1  vector fetch strobe from the processor module.
wbi_ack_o  out  1  vector fetch acknowledge, one-cycle pulse.
wbi_dat_o  out  16  vector data; valid while wbi_ack_o=1, held until the next delivery.

Behaviour:
- Reset (async, wb_rst_i=1): state=IDLE, iack_o=0, virq_o=0, wbi_ack_o=0, wbi_dat_o=0, hold counter=0. All outputs are registered.
- Assertion of reset mid-handshake aborts the cycle immediately. No ack or iack is issued afterwards. The strobe is then treated as new once reset is released.
- Priority encode: sel = lowest k with ireq_i[k]=1; pend = |ireq_i.
- State IDLE:
  - virq_o <= pend, i.e. one-cycle latency from request to virq.
  - If wbi_stb_i=1, the request vector is snapshotted in that cycle: sel, pend, and ivec_i of sel are captured.
  - The next edge sets wbi_ack_o=1 and wbi_dat_o = captured vector with bits [1:0] forced to 0. If pend=0, wbi_dat_o = NOVEC with bits [1:0] forced to 0.
  - iack_o[sel]=1 on the same cycle as the ack, and only if pend=1.
  - virq_o <= 0; state <= ACK.
  - Ack latency is exactly 1 cycle after strobe sampled.
- State ACK (one cycle): wbi_ack_o and iack_o are high. Next edge clears them.
  - If wbi_stb_i is still 1, state <= WAIT.
  - Otherwise state <= HOLD and the counter is loaded with HOLD. If HOLD=0, state <= IDLE.
- State WAIT: wait for wbi_stb_i=0. No further ack is issued for the same strobe; one ack is issued per strobe assertion. Then go to HOLD or IDLE as above.
- State HOLD: the counter decrements each cycle; at 0, state <= IDLE.
- virq_o is 0 in ACK, WAIT and HOLD. In IDLE it re-evaluates the current ireq_i.
- Request changes after the snapshot cycle do not affect the delivered vector or the iack target.
- Simultaneous requests: the lowest index wins. Others remain pending and are served on later fetches.
- If a request is withdrawn between virq_o assertion and the fetch, NOVEC is delivered and no iack is pulsed.
- A strobe arriving during HOLD is held off; it is serviced on the first IDLE cycle. Ack latency is then measured from that cycle.
- iack_o is one-hot or zero; never more than one bit is set.

Test Plan:
- Reset with ireq_i=8'h04 and wbi_stb_i=1 → all outputs 0 during reset. After release: virq_o=1 one cycle later, then ack per the IDLE rules.
- ireq_i=8'h04 with ivec_i[2]=16'o000064; assert wbi_stb_i for 3 cycles → wbi_ack_o=1 exactly one cycle after the strobe is sampled, for 1 cycle only. wbi_dat_o=16'o000064, iack_o=8'h04 in the ack cycle, and no second ack while the strobe stays high.
- ireq_i=8'h0A with vectors 16'o000100 (src1) and 16'o000300 (src3); two fetches, src1 dropping its request after its iack → first vector 16'o000100 with iack_o=8'h02, second 16'o000300 with iack_o=8'h08.
- After a delivery with HOLD=2 and ireq_i held high → virq_o stays 0 for the ACK cycle plus 2 hold cycles, then returns to 1 one cycle after IDLE is re-entered.
- Request dropped to 0 before wbi_stb_i → wbi_dat_o=NOVEC (0), iack_o=0, wbi_ack_o=1.
- ivec_i[0]=16'o000107 → wbi_dat_o=16'o000104. Assert wb_rst_i in the cycle of a pending ack → no ack or iack appears, and state is IDLE after release.
